// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one DATA_W-bit ALU between two valid/ready requesters.
// Round-robin arbitration in IDLE, single-cycle ops or an iterative restoring
// divider, and a tagged response held under backpressure.
// Optional feature macro: ALU_ARB_DIV_EN builds the divider and DIV state;
// without it op 3 reports an error like any illegal op.
//
// state | meaning
// IDLE  | waiting for an accept, READY follows the grant
// EXEC  | operands latched, single-cycle result or divider start
// DIV   | one restoring quotient bit per cycle, DATA_W cycles (divider builds only)
// RESP  | response valid, held until rsp_ready_i
module alu_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_W-1:0]     req0_a_i,
  input  logic [DATA_W-1:0]     req0_b_i,
  input  logic [3:0]            req0_op_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_W-1:0]     req1_a_i,
  input  logic [DATA_W-1:0]     req1_b_i,
  input  logic [3:0]            req1_op_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [2*DATA_W-1:0]   rsp_result_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int RW = 2 * DATA_W;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;

`ifdef ALU_ARB_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DIV = 2'd2, RESP = 2'd3} state_t;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd3} state_t;
`endif

  state_t state_q, state_d;

  logic              last_grant_q;
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic              id_q;
  logic [RW-1:0]     result_q;
  logic              err_q;
  logic [RW-1:0]     alu_res;
  logic              alu_err;
  logic              div_go;

`ifdef ALU_ARB_DIV_EN
  logic [DATA_W-1:0] rem_q, quo_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W:0]   shifted;
  logic              div_ge;
  logic [DATA_W-1:0] rem_nx, quo_nx;
`endif

  // Round-robin grant: a lone valid wins, a tie goes to the requester that did not win last.
  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid_i && !req1_valid_i) begin
      grant = 1'b0;
    end else if (req1_valid_i && !req0_valid_i) begin
      grant = 1'b1;
    end
    req0_ready_o = (state_q == IDLE) && (grant == 1'b0);
    req1_ready_o = (state_q == IDLE) && (grant == 1'b1);
    accept = (req0_ready_o && req0_valid_i) || (req1_ready_o && req1_valid_i);
  end

  // Single-cycle ALU on the latched operands; DIV by nonzero is handed to the divider.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    div_go  = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = RW'(a_q) + RW'(b_q);
      OP_SUB:  alu_res = (a_q >= b_q) ? RW'(a_q) - RW'(b_q) : '0;
      OP_MULT: alu_res = RW'(a_q) * RW'(b_q);
      OP_AND:  alu_res = RW'(a_q & b_q);
      OP_OR:   alu_res = RW'(a_q | b_q);
      OP_DIV: begin
`ifdef ALU_ARB_DIV_EN
        if (b_q == '0) begin
          alu_res = '1;
          alu_err = 1'b1;
        end else begin
          div_go = 1'b1;
        end
`else
        alu_err = 1'b1;
`endif
      end
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_ARB_DIV_EN
  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    div_ge  = shifted >= {1'b0, b_q};
    rem_nx  = div_ge ? DATA_W'(shifted - {1'b0, b_q}) : shifted[DATA_W-1:0];
    quo_nx  = {quo_q[DATA_W-2:0], div_ge};
  end
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
`ifdef ALU_ARB_DIV_EN
        if (div_go) state_d = DIV;
        else        state_d = RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef ALU_ARB_DIV_EN
      DIV:  if (cnt_q == '0) state_d = RESP;
`endif
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, arbitration history, result and divider registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
`ifdef ALU_ARB_DIV_EN
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      if (accept) begin
        last_grant_q <= grant;
        id_q         <= grant;
        a_q          <= grant ? req1_a_i  : req0_a_i;
        b_q          <= grant ? req1_b_i  : req0_b_i;
        op_q         <= grant ? req1_op_i : req0_op_i;
      end
      if (state_q == EXEC && !div_go) begin
        result_q <= alu_res;
        err_q    <= alu_err;
      end
`ifdef ALU_ARB_DIV_EN
      if (state_q == EXEC && div_go) begin
        rem_q <= '0;
        quo_q <= a_q;
        cnt_q <= CW'(DATA_W - 1);
      end
      if (state_q == DIV) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_q <= RW'(quo_nx);
          err_q    <= 1'b0;
        end
      end
`endif
    end
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (DATA_W = 4).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] a0, b0, op0, a1, b1, op1;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.DATA_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(a0), .req0_b_i(b0), .req0_op_i(op0),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(a1), .req1_b_i(b1), .req1_op_i(op1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
    .rsp_err_o(rsp_err), .busy_o(busy)
  );

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issues one request on requester id from IDLE; returns cycles from the accept
  // edge until rsp_valid is seen (-1 if never accepted, 30 on timeout).
  task automatic send(input bit id, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] op, output int lat);
    bit acc = 1'b0;
    if (id) begin a1 = a; b1 = b; op1 = op; req1_valid = 1'b1; end
    else    begin a0 = a; b0 = b; op0 = op; req0_valid = 1'b1; end
    for (int k = 0; k < 20 && !acc; k++) begin
      #1 acc = id ? req1_ready : req0_ready;
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!acc) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_result !== 8'h00) begin n_mis++; $display("FAIL reset_result got %h want 00", rsp_result); end
    n_cmp++; if ({rsp_err, rsp_id, busy} !== 3'b000) begin n_mis++; $display("FAIL reset_err_id_busy got %b want 000", {rsp_err, rsp_id, busy}); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    a0 = 4'd9; b0 = 4'd8; op0 = 4'd0; req0_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_mis++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if ({busy, rsp_valid} !== 2'b10) begin n_mis++; $display("FAIL add_n1 busy/valid got %b want 10", {busy, rsp_valid}); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, rsp_valid, rsp_err, rsp_id} !== 4'b1100) begin n_mis++; $display("FAIL add_n2 busy/valid/err/id got %b want 1100", {busy, rsp_valid, rsp_err, rsp_id}); end
    n_cmp++; if (rsp_result !== 8'h11) begin n_mis++; $display("FAIL add_result got %h want 11", rsp_result); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL add_idle busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back_tie();
    int last_t;
    int t;
    bit found;
    logic [7:0] exp_res;
    do_reset();
    rsp_ready = 1'b1;
    a0 = 4'hF; b0 = 4'hF; op0 = 4'd2;
    a1 = 4'd3; b1 = 4'd5; op1 = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    last_t = 0;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0; t = 0;
      while (!found && t < 20) begin
        @(posedge clk); #1;
        t++;
        if (rsp_valid) found = 1'b1;
      end
      if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      exp_res = (i % 2 == 0) ? 8'hE1 : 8'h00;
      n_cmp++; if (found !== 1'b1) begin n_mis++; $display("FAIL tie_timeout resp %0d not seen", i); end
      n_cmp++; if (rsp_id !== 1'(i % 2)) begin n_mis++; $display("FAIL tie_id resp %0d got %b want %0d", i, rsp_id, i % 2); end
      n_cmp++; if (rsp_result !== exp_res) begin n_mis++; $display("FAIL tie_result resp %0d got %h want %h", i, rsp_result, exp_res); end
      if (i > 0) begin
        n_cmp++; if (cyc - last_t !== 3) begin n_mis++; $display("FAIL tie_spacing resp %0d got %0d want 3", i, cyc - last_t); end
      end
      last_t = cyc;
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL tie_idle busy got %b want 0", busy); end
  endtask

  task automatic test_div();
    int lat;
    rsp_ready = 1'b1;
    send(1'b0, 4'd13, 4'd4, 4'd3, lat);
`ifdef ALU_ARB_DIV_EN
    n_cmp++; if (lat !== 6) begin n_mis++; $display("FAIL div_lat got %0d want 6", lat); end
    n_cmp++; if ({rsp_result, rsp_err} !== {8'h03, 1'b0}) begin n_mis++; $display("FAIL div_13_4 got %h err %b want 03 err 0", rsp_result, rsp_err); end
`else
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL div_off_lat got %0d want 2", lat); end
    n_cmp++; if ({rsp_result, rsp_err} !== {8'h00, 1'b1}) begin n_mis++; $display("FAIL div_off got %h err %b want 00 err 1", rsp_result, rsp_err); end
`endif
    @(posedge clk); #1;
    send(1'b1, 4'd15, 4'd1, 4'd3, lat);
`ifdef ALU_ARB_DIV_EN
    n_cmp++; if ({rsp_result, rsp_err, rsp_id} !== {8'h0F, 1'b0, 1'b1}) begin n_mis++; $display("FAIL div_15_1 got %h err %b id %b want 0f 0 1", rsp_result, rsp_err, rsp_id); end
`else
    n_cmp++; if ({rsp_result, rsp_err, rsp_id} !== {8'h00, 1'b1, 1'b1}) begin n_mis++; $display("FAIL div_off_15_1 got %h err %b id %b want 00 1 1", rsp_result, rsp_err, rsp_id); end
`endif
    @(posedge clk); #1;
    send(1'b0, 4'd7, 4'd0, 4'd3, lat);
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL div0_lat got %0d want 2", lat); end
`ifdef ALU_ARB_DIV_EN
    n_cmp++; if ({rsp_result, rsp_err} !== {8'hFF, 1'b1}) begin n_mis++; $display("FAIL div0 got %h err %b want ff err 1", rsp_result, rsp_err); end
`else
    n_cmp++; if ({rsp_result, rsp_err} !== {8'h00, 1'b1}) begin n_mis++; $display("FAIL div0_off got %h err %b want 00 err 1", rsp_result, rsp_err); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    rsp_ready = 1'b0;
    send(1'b1, 4'hC, 4'hA, 4'd4, lat);
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL bp_lat got %0d want 2", lat); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_result, rsp_id, rsp_err, req0_ready, req1_ready} !== {1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        n_mis++;
        $display("FAIL bp_hold cycle %0d got v%b r%h id%b e%b rdy%b%b want v1 r08 id1 e0 rdy00",
                 i, rsp_valid, rsp_result, rsp_id, rsp_err, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy, rsp_valid} !== 2'b00) begin n_mis++; $display("FAIL bp_release busy/valid got %b want 00", {busy, rsp_valid}); end
  endtask

  task automatic test_illegal();
    int lat;
    rsp_ready = 1'b1;
    send(1'b0, 4'd5, 4'd3, 4'hF, lat);
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL illegal_lat got %0d want 2", lat); end
    n_cmp++; if ({rsp_result, rsp_err} !== {8'h00, 1'b1}) begin n_mis++; $display("FAIL illegal got %h err %b want 00 err 1", rsp_result, rsp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    int t;
    rsp_ready = 1'b0;
    a0 = 4'd13; b0 = 4'd4; op0 = 4'd3; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
`ifdef ALU_ARB_DIV_EN
    @(posedge clk); #1;
`endif
    n_cmp++; if ({busy, rsp_valid} !== 2'b10) begin n_mis++; $display("FAIL rstmid_pre busy/valid got %b want 10", {busy, rsp_valid}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_err, rsp_id, busy} !== 12'h000) begin
      n_mis++;
      $display("FAIL rstmid_values got v%b r%h e%b id%b busy%b want all 0", rsp_valid, rsp_result, rsp_err, rsp_id, busy);
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_mis++; $display("FAIL rstmid_no_rsp got response want none"); end
    a0 = 4'd1; b0 = 4'd2; op0 = 4'd0;
    a1 = 4'd4; b1 = 4'd4; op1 = 4'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_mis++; $display("FAIL rstmid_tie ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 8'h03}) begin n_mis++; $display("FAIL rstmid_tie_rsp got v%b id%b r%h want v1 id0 r03", rsp_valid, rsp_id, rsp_result); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back_tie();
    test_div();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
